aurora_link_supervisor: RTL and testbench
=========================================

Name: aurora_link_supervisor

Overview:
Parametrised supervisor for NUM_CH Aurora 64B/66B channels that share one user_clk, one clock module and one QPLL.
- Each channel gets a sequencer: it drives that channel's IP reset, waits for channel_up and all lane_up bits, and qualifies the link as stable before declaring it usable.
- A linked channel is re-reset on hard error, on link drop, or on excessive soft errors.
- Per-channel statistics and state are exposed.
- Sits between the multi-channel Aurora top and the user traffic logic, in the user_clk domain.

Parameters:
NUM_CH, 2, number of Aurora channels supervised (1..8)
LANES_PER_CH, 2, lanes per channel (1..4)
RESET_HOLD, 64, cycles ch_reset is held per reset attempt (>=2)
UP_TIMEOUT, 65536, cycles to wait for channel up before a retry (>=4)
STABLE_CYCLES, 1024, consecutive up cycles required before link_ok (>=1)
MAX_RETRY, 8, consecutive failed attempts before FAILED (>=1)
SOFT_ERR_THRESH, 16, soft errors within one window that force a re-reset (>=1)
SOFT_ERR_WINDOW, 4096, soft-error window length in cycles (> SOFT_ERR_THRESH)
CNT_W, 16, statistics counter width

Ports:
user_clk  in  1  Aurora user clock; the only clock
system_rst  in  1  asynchronous active-high reset
ch_enable  in  NUM_CH  per-channel enable; low forces DISABLED
clr_stats  in  1  single-cycle pulse that clears all statistics counters
channel_up  in  NUM_CH  from Aurora IP
lane_up  in  NUM_CH*LANES_PER_CH  from Aurora IP; channel c owns bits [c*L +: L]
hard_err  in  NUM_CH  from Aurora IP
soft_err  in  NUM_CH  from Aurora IP
ch_reset  out  NUM_CH  reset to each channel's IP (reset_pb/user_sys_reset path)
link_ok  out  NUM_CH  channel is qualified for traffic
ch_failed  out  NUM_CH  retry limit exhausted
ch_state  out  NUM_CH*3  current state encoding per channel
soft_err_cnt  out  NUM_CH*CNT_W  cumulative soft errors, saturating
link_drop_cnt  out  NUM_CH*CNT_W  re-resets issued from LINKED, saturating

Behaviour:
- Reset (system_rst=1) values: every channel is in RST_HOLD with all timers and retry counts 0. Outputs: ch_reset all 1, link_ok 0, ch_failed 0, all counters 0.
- States: DISABLED=0, RST_HOLD=1, WAIT_UP=2, STABLE=3, LINKED=4, FAILED=5. All outputs are registered Moore outputs decoded from the state.
- ch_reset is 1 in DISABLED, RST_HOLD and FAILED. link_ok is 1 only in LINKED. ch_failed is 1 only in FAILED.
- up_c = channel_up[c] AND every lane_up bit of channel c.
- Any state with ch_enable[c]=0 goes to DISABLED next cycle. This has highest priority and clears the retry count.
- DISABLED, ch_enable=1: go to RST_HOLD with timer cleared.
- RST_HOLD: after exactly RESET_HOLD cycles in the state, go to WAIT_UP with timer cleared.
- WAIT_UP:
  - up_c: go to STABLE, timer cleared.
  - Timer reaches UP_TIMEOUT-1: retry+1. If the new retry value equals MAX_RETRY go to FAILED, else go to RST_HOLD.
- STABLE:
  - up_c low, or hard_err: retry+1, then apply the same FAILED/RST_HOLD rule as WAIT_UP.
  - STABLE_CYCLES consecutive up_c cycles: go to LINKED and clear retry.
- LINKED: re-reset triggers, in priority order:
  1. hard_err
  2. up_c low
  3. in-window soft count reaches SOFT_ERR_THRESH
  Any trigger: go to RST_HOLD and link_drop_cnt+1. Retry is unchanged (it is 0).
- Soft-error window: a per-channel free-running counter that wraps at SOFT_ERR_WINDOW-1.
  - The in-window count is cleared on wrap and on entry to LINKED.
  - A soft_err on the wrap cycle counts into the new window.
- FAILED: terminal. The only exit is ch_enable[c]=0 (to DISABLED).
- soft_err_cnt increments on every soft_err cycle in every state except DISABLED.
- Statistics counters saturate at 2^CNT_W-1.
- clr_stats takes precedence over a same-cycle increment: the result is 0.
- Channels are fully independent; no shared state besides clr_stats.
- hard_err and soft_err on the same cycle in LINKED: the hard_err path is taken and the soft count still increments.
- Reset asserted mid-operation returns all channels to RST_HOLD asynchronously.

Decomposition:
- Package aurora_sup_pkg holds:
  - the sup_state_e enum (3-bit, values above)
  - the state-code localparams shared with the status-register block
  - a function returning the counter width via $clog2(max(RESET_HOLD, UP_TIMEOUT, STABLE_CYCLES)+1)
- Sub-module aurora_link_ch_fsm: one channel (FSM, timers, window, counters), instantiated NUM_CH times in a generate loop. The top only slices vectors and fans out clr_stats.

Test Plan:
Bench parameters: RESET_HOLD=4, UP_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRY=3, SOFT_ERR_THRESH=4, SOFT_ERR_WINDOW=64, NUM_CH=2.
- Bring-up: release reset, raise channel_up[0] and lane_up[1:0]=2'b11 at cycle 10.
  -> ch_reset[0] falls after exactly 4 cycles; link_ok[0] rises 8 cycles after up; ch_state[2:0]=4.
- Retry exhaustion: never raise up on ch1.
  -> three 4+20 cycle attempts, then ch_failed[1]=1 with ch_reset[1]=1; toggling ch_enable[1] 0→1 restarts in RST_HOLD.
- Partial lanes: channel_up=1 but lane_up=2'b01.
  -> channel stays in WAIT_UP and times out; link_ok stays 0.
- Soft burst: in LINKED, 4 soft_err pulses within 64 cycles.
  -> RST_HOLD, link_drop_cnt=1, soft_err_cnt=4. 3 pulses per window spanning a wrap -> no reset.
- Hard error and drop: single-cycle hard_err in LINKED -> re-reset with link_drop_cnt+1. channel_up low for 1 cycle in STABLE -> retry+1.
- Stats and reset: clr_stats coincident with soft_err -> soft_err_cnt=0. Assert system_rst while LINKED -> ch_reset=1 and link_ok=0 immediately (asynchronously).

Source files
------------

// File: rtl/aurora_sup_pkg.sv
// Shared state codes, state enum and timer-width helper for the Aurora link supervisor.
// Pure definitions: no logic, no latency, no flow control.
package aurora_sup_pkg;

   localparam int         SUP_STATE_W        = 3;
   localparam logic [2:0] SUP_CODE_DISABLED  = 3'd0;
   localparam logic [2:0] SUP_CODE_RST_HOLD  = 3'd1;
   localparam logic [2:0] SUP_CODE_WAIT_UP   = 3'd2;
   localparam logic [2:0] SUP_CODE_STABLE    = 3'd3;
   localparam logic [2:0] SUP_CODE_LINKED    = 3'd4;
   localparam logic [2:0] SUP_CODE_FAILED    = 3'd5;

   typedef enum logic [2:0] {
      ST_DISABLED = SUP_CODE_DISABLED,
      ST_RST_HOLD = SUP_CODE_RST_HOLD,
      ST_WAIT_UP  = SUP_CODE_WAIT_UP,
      ST_STABLE   = SUP_CODE_STABLE,
      ST_LINKED   = SUP_CODE_LINKED,
      ST_FAILED   = SUP_CODE_FAILED
   } sup_state_e;

   function automatic int sup_tmr_width(input int rst_hold, input int up_timeout,
                                        input int stable_cycles);
      int m;
      m = rst_hold;
      if (up_timeout > m) m = up_timeout;
      if (stable_cycles > m) m = stable_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/aurora_link_ch_fsm.sv
// One-channel bring-up sequencer with soft-error window and saturating statistics.
// All outputs are registered from the next state (1-cycle latency); no backpressure.
module aurora_link_ch_fsm
   import aurora_sup_pkg::*;
#(
   parameter int LANES_PER_CH    = 2,
   parameter int RESET_HOLD      = 64,
   parameter int UP_TIMEOUT      = 65536,
   parameter int STABLE_CYCLES   = 1024,
   parameter int MAX_RETRY       = 8,
   parameter int SOFT_ERR_THRESH = 16,
   parameter int SOFT_ERR_WINDOW = 4096,
   parameter int CNT_W           = 16
)(
   input  logic                    i_clk,
   input  logic                    i_rst,
   input  logic                    i_enable,
   input  logic                    i_clr_stats,
   input  logic                    i_channel_up,
   input  logic [LANES_PER_CH-1:0] i_lane_up,
   input  logic                    i_hard_err,
   input  logic                    i_soft_err,
   output logic                    o_ch_reset,
   output logic                    o_link_ok,
   output logic                    o_ch_failed,
   output logic [SUP_STATE_W-1:0]  o_state,
   output logic [CNT_W-1:0]        o_soft_err_cnt,
   output logic [CNT_W-1:0]        o_link_drop_cnt
);

   localparam int TMR_W = sup_tmr_width(RESET_HOLD, UP_TIMEOUT, STABLE_CYCLES);
   localparam int RTY_W = $clog2(MAX_RETRY + 1);
   localparam int WIN_W = $clog2(SOFT_ERR_WINDOW);
   localparam int SWC_W = $clog2(SOFT_ERR_THRESH + 1);

   localparam logic [TMR_W-1:0] HOLD_LAST  = TMR_W'(RESET_HOLD - 1);
   localparam logic [TMR_W-1:0] UP_LAST    = TMR_W'(UP_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] STB_LAST   = TMR_W'(STABLE_CYCLES - 1);
   localparam logic [RTY_W-1:0] RTY_MAX    = RTY_W'(MAX_RETRY);
   localparam logic [WIN_W-1:0] WIN_LAST   = WIN_W'(SOFT_ERR_WINDOW - 1);
   localparam logic [SWC_W-1:0] SWC_THRESH = SWC_W'(SOFT_ERR_THRESH);

   sup_state_e       r_state;
   logic [TMR_W-1:0] r_timer;
   logic [RTY_W-1:0] r_retry;
   logic [WIN_W-1:0] r_win;
   logic [SWC_W-1:0] r_soft_win;
   logic [CNT_W-1:0] r_soft_cnt;
   logic [CNT_W-1:0] r_drop_cnt;
   logic             r_ch_reset;
   logic             r_link_ok;
   logic             r_ch_failed;

   sup_state_e       w_state_nxt;
   logic [TMR_W-1:0] w_timer_nxt;
   logic [RTY_W-1:0] w_retry_nxt;
   logic [RTY_W-1:0] w_retry_inc;
   logic [SWC_W-1:0] w_soft_base;
   logic [SWC_W-1:0] w_soft_win_nxt;
   logic             w_up;
   logic             w_win_wrap;
   logic             w_drop;
   logic             w_enter_linked;

   assign w_up        = i_channel_up & (&i_lane_up);
   assign w_retry_inc = r_retry + 1'b1;
   assign w_win_wrap  = (r_win == WIN_LAST);
   // A soft error on the wrap cycle lands in the fresh window.
   assign w_soft_base    = w_win_wrap ? '0 : r_soft_win;
   assign w_soft_win_nxt = (w_soft_base == SWC_THRESH) ? w_soft_base : w_soft_base + i_soft_err;

   always_comb begin
      w_state_nxt    = r_state;
      w_timer_nxt    = r_timer + 1'b1;
      w_retry_nxt    = r_retry;
      w_drop         = 1'b0;
      w_enter_linked = 1'b0;
      if (!i_enable) begin
         w_state_nxt = ST_DISABLED;
         w_timer_nxt = '0;
         w_retry_nxt = '0;
      end else begin
         case (r_state)
            ST_DISABLED: begin
               w_state_nxt = ST_RST_HOLD;
               w_timer_nxt = '0;
            end
            ST_RST_HOLD: begin
               if (r_timer == HOLD_LAST) begin
                  w_state_nxt = ST_WAIT_UP;
                  w_timer_nxt = '0;
               end
            end
            ST_WAIT_UP: begin
               if (w_up) begin
                  w_state_nxt = ST_STABLE;
                  w_timer_nxt = '0;
               end else if (r_timer == UP_LAST) begin
                  w_retry_nxt = w_retry_inc;
                  w_state_nxt = (w_retry_inc == RTY_MAX) ? ST_FAILED : ST_RST_HOLD;
                  w_timer_nxt = '0;
               end
            end
            ST_STABLE: begin
               if (!w_up || i_hard_err) begin
                  w_retry_nxt = w_retry_inc;
                  w_state_nxt = (w_retry_inc == RTY_MAX) ? ST_FAILED : ST_RST_HOLD;
                  w_timer_nxt = '0;
               end else if (r_timer == STB_LAST) begin
                  w_state_nxt    = ST_LINKED;
                  w_retry_nxt    = '0;
                  w_timer_nxt    = '0;
                  w_enter_linked = 1'b1;
               end
            end
            ST_LINKED: begin
               w_timer_nxt = '0;
               if (i_hard_err || !w_up || (w_soft_win_nxt == SWC_THRESH)) begin
                  w_state_nxt = ST_RST_HOLD;
                  w_drop      = 1'b1;
               end
            end
            ST_FAILED: w_timer_nxt = '0;
            default: begin
               w_state_nxt = ST_RST_HOLD;
               w_timer_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state     <= ST_RST_HOLD;
         r_timer     <= '0;
         r_retry     <= '0;
         r_win       <= '0;
         r_soft_win  <= '0;
         r_soft_cnt  <= '0;
         r_drop_cnt  <= '0;
         r_ch_reset  <= 1'b1;
         r_link_ok   <= 1'b0;
         r_ch_failed <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_timer     <= w_timer_nxt;
         r_retry     <= w_retry_nxt;
         r_win       <= w_win_wrap ? '0 : r_win + 1'b1;
         r_soft_win  <= w_enter_linked ? '0 : w_soft_win_nxt;
         r_ch_reset  <= (w_state_nxt == ST_DISABLED) || (w_state_nxt == ST_RST_HOLD) ||
                        (w_state_nxt == ST_FAILED);
         r_link_ok   <= (w_state_nxt == ST_LINKED);
         r_ch_failed <= (w_state_nxt == ST_FAILED);
         if (i_clr_stats)
            r_soft_cnt <= '0;
         else if (i_soft_err && (r_state != ST_DISABLED) && (r_soft_cnt != '1))
            r_soft_cnt <= r_soft_cnt + 1'b1;
         if (i_clr_stats)
            r_drop_cnt <= '0;
         else if (w_drop && (r_drop_cnt != '1))
            r_drop_cnt <= r_drop_cnt + 1'b1;
      end
   end

   assign o_ch_reset      = r_ch_reset;
   assign o_link_ok       = r_link_ok;
   assign o_ch_failed     = r_ch_failed;
   assign o_state         = r_state;
   assign o_soft_err_cnt  = r_soft_cnt;
   assign o_link_drop_cnt = r_drop_cnt;

endmodule

// File: rtl/aurora_link_supervisor.sv
// Supervises NUM_CH independent Aurora channels in the user_clk domain; slices buses per channel.
// Outputs registered inside each channel (1-cycle latency); no backpressure.
module aurora_link_supervisor
   import aurora_sup_pkg::*;
#(
   parameter int NUM_CH          = 2,
   parameter int LANES_PER_CH    = 2,
   parameter int RESET_HOLD      = 64,
   parameter int UP_TIMEOUT      = 65536,
   parameter int STABLE_CYCLES   = 1024,
   parameter int MAX_RETRY       = 8,
   parameter int SOFT_ERR_THRESH = 16,
   parameter int SOFT_ERR_WINDOW = 4096,
   parameter int CNT_W           = 16
)(
   input  logic                             user_clk,
   input  logic                             system_rst,
   input  logic [NUM_CH-1:0]                ch_enable,
   input  logic                             clr_stats,
   input  logic [NUM_CH-1:0]                channel_up,
   input  logic [NUM_CH*LANES_PER_CH-1:0]   lane_up,
   input  logic [NUM_CH-1:0]                hard_err,
   input  logic [NUM_CH-1:0]                soft_err,
   output logic [NUM_CH-1:0]                ch_reset,
   output logic [NUM_CH-1:0]                link_ok,
   output logic [NUM_CH-1:0]                ch_failed,
   output logic [NUM_CH*SUP_STATE_W-1:0]    ch_state,
   output logic [NUM_CH*CNT_W-1:0]          soft_err_cnt,
   output logic [NUM_CH*CNT_W-1:0]          link_drop_cnt
);

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      aurora_link_ch_fsm #(
         .LANES_PER_CH    (LANES_PER_CH),
         .RESET_HOLD      (RESET_HOLD),
         .UP_TIMEOUT      (UP_TIMEOUT),
         .STABLE_CYCLES   (STABLE_CYCLES),
         .MAX_RETRY       (MAX_RETRY),
         .SOFT_ERR_THRESH (SOFT_ERR_THRESH),
         .SOFT_ERR_WINDOW (SOFT_ERR_WINDOW),
         .CNT_W           (CNT_W)
      ) u_ch (
         .i_clk           (user_clk),
         .i_rst           (system_rst),
         .i_enable        (ch_enable[g]),
         .i_clr_stats     (clr_stats),
         .i_channel_up    (channel_up[g]),
         .i_lane_up       (lane_up[g*LANES_PER_CH +: LANES_PER_CH]),
         .i_hard_err      (hard_err[g]),
         .i_soft_err      (soft_err[g]),
         .o_ch_reset      (ch_reset[g]),
         .o_link_ok       (link_ok[g]),
         .o_ch_failed     (ch_failed[g]),
         .o_state         (ch_state[g*SUP_STATE_W +: SUP_STATE_W]),
         .o_soft_err_cnt  (soft_err_cnt[g*CNT_W +: CNT_W]),
         .o_link_drop_cnt (link_drop_cnt[g*CNT_W +: CNT_W])
      );
   end

endmodule

// File: tb/tb_aurora_link_supervisor.sv
// Directed bench for aurora_link_supervisor: stimulus queues expectations, a negedge monitor checks them.
module tb_aurora_link_supervisor;

   localparam int NUM_CH = 2;
   localparam int L      = 2;
   localparam int CNT_W  = 16;

   localparam int K_STATE = 0;
   localparam int K_RST   = 1;
   localparam int K_OK    = 2;
   localparam int K_FAIL  = 3;
   localparam int K_SOFT  = 4;
   localparam int K_DROP  = 5;

   logic                  user_clk = 1'b0;
   logic                  system_rst;
   logic [NUM_CH-1:0]     ch_enable;
   logic                  clr_stats;
   logic [NUM_CH-1:0]     channel_up;
   logic [NUM_CH*L-1:0]   lane_up;
   logic [NUM_CH-1:0]     hard_err;
   logic [NUM_CH-1:0]     soft_err;
   logic [NUM_CH-1:0]     ch_reset;
   logic [NUM_CH-1:0]     link_ok;
   logic [NUM_CH-1:0]     ch_failed;
   logic [NUM_CH*3-1:0]   ch_state;
   logic [NUM_CH*CNT_W-1:0] soft_err_cnt;
   logic [NUM_CH*CNT_W-1:0] link_drop_cnt;

   aurora_link_supervisor #(
      .NUM_CH(NUM_CH), .LANES_PER_CH(L), .RESET_HOLD(4), .UP_TIMEOUT(20),
      .STABLE_CYCLES(8), .MAX_RETRY(3), .SOFT_ERR_THRESH(4), .SOFT_ERR_WINDOW(64),
      .CNT_W(CNT_W)
   ) dut (
      .user_clk(user_clk), .system_rst(system_rst), .ch_enable(ch_enable),
      .clr_stats(clr_stats), .channel_up(channel_up), .lane_up(lane_up),
      .hard_err(hard_err), .soft_err(soft_err), .ch_reset(ch_reset),
      .link_ok(link_ok), .ch_failed(ch_failed), .ch_state(ch_state),
      .soft_err_cnt(soft_err_cnt), .link_drop_cnt(link_drop_cnt)
   );

   always #5 user_clk = ~user_clk;

   typedef struct {
      int kind;
      int ch;
      int val;
      int edge_no;
   } exp_t;

   exp_t sb_q[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;

   function automatic string kname(input int k);
      case (k)
         K_STATE: return "ch_state";
         K_RST:   return "ch_reset";
         K_OK:    return "link_ok";
         K_FAIL:  return "ch_failed";
         K_SOFT:  return "soft_err_cnt";
         default: return "link_drop_cnt";
      endcase
   endfunction

   function automatic int actual(input int k, input int c);
      case (k)
         K_STATE: return int'(ch_state[c*3 +: 3]);
         K_RST:   return int'(ch_reset[c]);
         K_OK:    return int'(link_ok[c]);
         K_FAIL:  return int'(ch_failed[c]);
         K_SOFT:  return int'(soft_err_cnt[c*CNT_W +: CNT_W]);
         default: return int'(link_drop_cnt[c*CNT_W +: CNT_W]);
      endcase
   endfunction

   // Monitor: drains every queued expectation against the outputs at the falling edge.
   initial begin
      exp_t e;
      int   a;
      forever begin
         @(negedge user_clk);
         while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            a = actual(e.kind, e.ch);
            n_checks++;
            if (a !== e.val) begin
               n_fail++;
               $display("FAIL %s[%0d] after edge %0d: actual %0d, expected %0d",
                        kname(e.kind), e.ch, e.edge_no, a, e.val);
            end
         end
      end
   end

   task automatic chk(input int kind, input int ch, input int val);
      exp_t e;
      e.kind = kind; e.ch = ch; e.val = val; e.edge_no = cyc;
      sb_q.push_back(e);
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
      cyc++;
   endtask

   task automatic goto(input int n);
      while (cyc < n) tick();
   endtask

   task automatic pulse_soft(input int ch, input int at_edge);
      goto(at_edge - 1);
      soft_err[ch] = 1'b1;
      tick();
      soft_err[ch] = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not complete, edge %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      system_rst = 1'b0; ch_enable = '1; clr_stats = 1'b0; channel_up = '0;
      lane_up = '0; hard_err = '0; soft_err = '0;
      #2 system_rst = 1'b1;
      repeat (3) @(posedge user_clk);
      #1;
      for (int c = 0; c < NUM_CH; c++) begin
         chk(K_STATE, c, 1); chk(K_RST, c, 1); chk(K_OK, c, 0);
         chk(K_FAIL, c, 0);  chk(K_SOFT, c, 0); chk(K_DROP, c, 0);
      end
      system_rst = 1'b0;
      cyc = 0;

      // Bring-up of ch0; ch1 never comes up.
      goto(3);  chk(K_STATE, 0, 1); chk(K_RST, 0, 1); chk(K_RST, 1, 1);
      goto(4);  chk(K_STATE, 0, 2); chk(K_RST, 0, 0); chk(K_STATE, 1, 2);
      goto(10); channel_up[0] = 1'b1; lane_up[1:0] = 2'b11;
      goto(18); chk(K_STATE, 0, 3); chk(K_OK, 0, 0);
      goto(19); chk(K_STATE, 0, 4); chk(K_OK, 0, 1); chk(K_RST, 0, 0);
      goto(23); chk(K_STATE, 1, 2);
      goto(24); chk(K_STATE, 1, 1); chk(K_RST, 1, 1);

      // Three soft errors either side of the wrap at edge 64: no re-reset.
      pulse_soft(0, 60); pulse_soft(0, 62); pulse_soft(0, 63);
      pulse_soft(0, 64); pulse_soft(0, 65); pulse_soft(0, 66);
      goto(70); chk(K_STATE, 0, 4); chk(K_SOFT, 0, 6); chk(K_DROP, 0, 0);

      goto(71); chk(K_STATE, 1, 2); chk(K_FAIL, 1, 0);
      goto(72); chk(K_STATE, 1, 5); chk(K_FAIL, 1, 1); chk(K_RST, 1, 1);

      pulse_soft(1, 75); pulse_soft(1, 76); chk(K_SOFT, 1, 2);
      goto(77); clr_stats = 1'b1; soft_err[1] = 1'b1;
      tick();   clr_stats = 1'b0; soft_err[1] = 1'b0;
      chk(K_SOFT, 1, 0); chk(K_SOFT, 0, 0);

      // Re-enable of the failed ch1 restarts with a cleared retry count.
      goto(89); ch_enable[1] = 1'b0;
      tick();   chk(K_STATE, 1, 0); chk(K_RST, 1, 1); chk(K_FAIL, 1, 0);
      pulse_soft(1, 91); chk(K_STATE, 1, 0); chk(K_SOFT, 1, 0);
      ch_enable[1] = 1'b1;
      tick();   chk(K_STATE, 1, 1); chk(K_RST, 1, 1);
      goto(115); chk(K_STATE, 1, 2);
      goto(116); chk(K_STATE, 1, 1); chk(K_FAIL, 1, 0);

      // Four soft errors inside one window force a re-reset.
      pulse_soft(0, 130); pulse_soft(0, 131); pulse_soft(0, 132);
      chk(K_STATE, 0, 4); chk(K_SOFT, 0, 3);
      pulse_soft(0, 133);
      chk(K_STATE, 0, 1); chk(K_DROP, 0, 1); chk(K_SOFT, 0, 4); chk(K_OK, 0, 0); chk(K_RST, 0, 1);
      goto(146); chk(K_STATE, 0, 4); chk(K_OK, 0, 1);

      goto(149); hard_err[0] = 1'b1; soft_err[0] = 1'b1;
      tick();    hard_err[0] = 1'b0; soft_err[0] = 1'b0;
      chk(K_STATE, 0, 1); chk(K_DROP, 0, 2); chk(K_SOFT, 0, 5);

      // Drop in STABLE uses a retry, then partial lanes time out twice more into FAILED.
      goto(157); chk(K_STATE, 0, 3); channel_up[0] = 1'b0;
      tick();    chk(K_STATE, 0, 1); chk(K_DROP, 0, 2); chk(K_RST, 0, 1);
      channel_up[0] = 1'b1; lane_up[1:0] = 2'b01;
      goto(181); chk(K_STATE, 0, 2); chk(K_OK, 0, 0);
      goto(182); chk(K_STATE, 0, 1);
      goto(205); chk(K_STATE, 0, 2);
      goto(206); chk(K_STATE, 0, 5); chk(K_FAIL, 0, 1); chk(K_RST, 0, 1);

      goto(209); ch_enable[0] = 1'b0; lane_up[1:0] = 2'b11;
      tick();    chk(K_STATE, 0, 0); chk(K_FAIL, 0, 0);
      tick();    ch_enable[0] = 1'b1;
      goto(224); chk(K_STATE, 0, 3);
      goto(225); chk(K_STATE, 0, 4); chk(K_OK, 0, 1);

      // Reset mid-cycle: outputs must change before any further clock edge.
      tick();
      #2 system_rst = 1'b1;
      chk(K_STATE, 0, 1); chk(K_RST, 0, 1); chk(K_OK, 0, 0);
      chk(K_DROP, 0, 0);  chk(K_SOFT, 0, 0); chk(K_STATE, 1, 1);

      repeat (2) tick();
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
